// File: rtl/mips_loader_pkg.sv
// Shared types and default geometry for the instruction-memory loader and the core top it feeds.
package mips_loader_pkg;

   localparam int unsigned MEM_BYTES_DEF = 256;
   localparam int unsigned ADDR_W_DEF    = 8;
   localparam int unsigned DLY_W         = 4;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      PAD,
      SETTLE,
      RUN
   } loader_state_t;

endpackage

// File: rtl/loader_mem_array.sv
// Byte-addressed single-write-port memory; async reset fills every byte with FILL_BYTE.
module loader_mem_array #(
   parameter int unsigned MEM_BYTES = 256,
   parameter int unsigned ADDR_W    = 8,
   parameter logic [7:0]  FILL_BYTE = 8'h00
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       we_i,
   input  logic [ADDR_W-1:0]          waddr_i,
   input  logic [7:0]                 wdata_i,
   output logic [MEM_BYTES-1:0][7:0]  mem_o
);

   logic [MEM_BYTES-1:0][7:0] mem_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= {MEM_BYTES{FILL_BYTE}};
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign mem_o = mem_q;

endmodule

// File: rtl/instruction_loader.sv
// Streams an instruction image into memory, pads the tail, and holds the core in reset until done.
module instruction_loader
   import mips_loader_pkg::*;
#(
   parameter int unsigned MEM_BYTES     = MEM_BYTES_DEF,
   parameter int unsigned ADDR_W        = ADDR_W_DEF,
   parameter logic [7:0]  FILL_BYTE     = 8'h00,
   parameter int unsigned RELEASE_DELAY = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start_load,
   input  logic                       in_valid,
   input  logic [7:0]                 in_data,
   input  logic                       in_last,
   output logic                       in_ready,
   output logic [MEM_BYTES-1:0][7:0]  instruction_mem,
   output logic                       core_reset,
   output logic                       load_done,
   output logic                       overflow_err,
   output logic [ADDR_W:0]            byte_count
);

   localparam int unsigned       CNT_W     = ADDR_W + 1;
   localparam logic [CNT_W-1:0]  FULL      = CNT_W'(MEM_BYTES);
   localparam logic [CNT_W-1:0]  LAST_ADDR = CNT_W'(MEM_BYTES - 1);
   localparam logic [DLY_W-1:0]  DLY_END   = DLY_W'(RELEASE_DELAY - 1);

   loader_state_t    state_q, state_d;
   logic [CNT_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DLY_W-1:0] dly_q, dly_d;
   logic             ovf_q, ovf_d;
   logic             in_ready_q, core_reset_q, load_done_q;
   logic             we_c;
   logic [7:0]       wdata_c;
   logic             xfer_c;
   logic             room_c;

   assign xfer_c = in_valid & in_ready_q;
   assign room_c = (ptr_q < FULL);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         cnt_q        <= '0;
         dly_q        <= '0;
         ovf_q        <= 1'b0;
         in_ready_q   <= 1'b0;
         core_reset_q <= 1'b1;
         load_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         dly_q        <= dly_d;
         ovf_q        <= ovf_d;
         in_ready_q   <= (state_d == LOAD);
         core_reset_q <= (state_d != RUN);
         load_done_q  <= (state_d == RUN);
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      dly_d   = dly_q;
      ovf_d   = ovf_q;
      we_c    = 1'b0;
      wdata_c = FILL_BYTE;
      case (state_q)
         IDLE, RUN: begin
            if (start_load) begin
               state_d = LOAD;
               ptr_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         LOAD: begin
            // Bytes beyond the array are drained and flagged until the image ends.
            if (xfer_c) begin
               if (room_c) begin
                  we_c    = 1'b1;
                  wdata_c = in_data;
                  ptr_d   = ptr_q + CNT_W'(1);
                  cnt_d   = cnt_q + CNT_W'(1);
               end else begin
                  ovf_d = 1'b1;
               end
               if (in_last) begin
                  dly_d   = '0;
                  state_d = (ptr_d < FULL) ? PAD : SETTLE;
               end
            end
         end
         PAD: begin
            we_c  = 1'b1;
            ptr_d = ptr_q + CNT_W'(1);
            if (ptr_q == LAST_ADDR) begin
               dly_d   = '0;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (dly_q == DLY_END) begin
               state_d = RUN;
            end else begin
               dly_d = dly_q + DLY_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   loader_mem_array #(
      .MEM_BYTES (MEM_BYTES),
      .ADDR_W    (ADDR_W),
      .FILL_BYTE (FILL_BYTE)
   ) u_mem (
      .clk     (clk),
      .rst_n   (reset),
      .we_i    (we_c),
      .waddr_i (ptr_q[ADDR_W-1:0]),
      .wdata_i (wdata_c),
      .mem_o   (instruction_mem)
   );

   assign in_ready     = in_ready_q;
   assign core_reset   = core_reset_q;
   assign load_done    = load_done_q;
   assign overflow_err = ovf_q;
   assign byte_count   = cnt_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: image-level memory model plus per-cycle output compare.
module tb_instruction_loader;

   localparam int unsigned MB   = 256;
   localparam logic [7:0]  FILL = 8'h00;
   localparam int unsigned RD   = 2;

   typedef logic [7:0] bq_t[$];

   logic              clk = 1'b0;
   logic              reset_n;
   logic              start_load, in_valid, in_last;
   logic [7:0]        in_data;
   logic              in_ready, core_reset, load_done, overflow_err;
   logic [MB-1:0][7:0] instruction_mem;
   logic [8:0]        byte_count;

   int unsigned checks = 0;
   int unsigned errors = 0;

   logic [MB-1:0][7:0] exp_mem;
   int   exp_cnt;
   bit   exp_ovf, exp_cr, exp_done, exp_ready, chk_en;
   longint last_t, fall_t;

   instruction_loader #(
      .MEM_BYTES     (MB),
      .ADDR_W        (8),
      .FILL_BYTE     (FILL),
      .RELEASE_DELAY (RD)
   ) dut (
      .clk             (clk),
      .reset           (reset_n),
      .start_load      (start_load),
      .in_valid        (in_valid),
      .in_data         (in_data),
      .in_last         (in_last),
      .in_ready        (in_ready),
      .instruction_mem (instruction_mem),
      .core_reset      (core_reset),
      .load_done       (load_done),
      .overflow_err    (overflow_err),
      .byte_count      (byte_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the image model, away from the active edge.
   always @(negedge clk) begin
      int bad;
      if (chk_en) begin
         bad = -1;
         for (int i = MB - 1; i >= 0; i--)
            if (instruction_mem[i] !== exp_mem[i]) bad = i;
         checks++;
         if (bad >= 0) begin
            errors++;
            $display("FAIL mem[%0d]: got %0h expected %0h at %0t",
                     bad, instruction_mem[bad], exp_mem[bad], $time);
         end
         chk("in_ready", 32'(in_ready), 32'(exp_ready));
         chk("core_reset", 32'(core_reset), 32'(exp_cr));
         chk("load_done", 32'(load_done), 32'(exp_done));
         chk("overflow_err", 32'(overflow_err), 32'(exp_ovf));
         chk("byte_count", 32'(byte_count), 32'(exp_cnt));
      end
   end

   always @(negedge core_reset) fall_t = $time;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic edge_();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      exp_mem   = {MB{FILL}};
      exp_cnt   = 0;
      exp_ovf   = 1'b0;
      exp_cr    = 1'b1;
      exp_done  = 1'b0;
      exp_ready = 1'b0;
   endtask

   task automatic start();
      start_load = 1'b1;
      edge_();
      start_load = 1'b0;
      exp_cnt   = 0;
      exp_ovf   = 1'b0;
      exp_ready = 1'b1;
      exp_cr    = 1'b1;
      exp_done  = 1'b0;
   endtask

   // Offer bytes with the given valid density; in_last is held on the final byte even while idle.
   task automatic stream(input bq_t d, input int pct, input bit give_last);
      int i   = 0;
      int cyc = 0;
      while (i < d.size()) begin
         bit v;
         v        = (pct >= 100) || (int'($urandom_range(99)) < pct);
         in_valid = v;
         in_data  = v ? d[i] : 8'($urandom);
         in_last  = give_last && (i == d.size() - 1);
         edge_();
         if (v) begin
            if (exp_cnt < MB) begin
               exp_mem[exp_cnt] = d[i];
               exp_cnt++;
            end else begin
               exp_ovf = 1'b1;
            end
            if (in_last) begin
               exp_ready = 1'b0;
               last_t    = $time - 1;
            end
            i++;
         end
         cyc++;
         if (cyc > 5000) begin
            checks++;
            errors++;
            $display("FAIL stream_timeout: got %0d bytes expected %0d", i, d.size());
            break;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic finish_load();
      int pad = MB - exp_cnt;
      for (int k = 0; k < pad; k++) begin
         edge_();
         exp_mem[MB - pad + k] = FILL;
      end
      for (int r = 0; r < int'(RD); r++) begin
         edge_();
         if (r == int'(RD) - 1) begin
            exp_cr   = 1'b0;
            exp_done = 1'b1;
         end
      end
      edge_();
      edge_();
   endtask

   initial begin
      bq_t q;
      chk_en     = 1'b0;
      reset_n    = 1'b0;
      start_load = 1'b0;
      in_valid   = 1'b0;
      in_last    = 1'b0;
      in_data    = 8'h00;
      fall_t     = 0;
      last_t     = 0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      chk_en = 1'b1;
      chk("rst_core_reset", 32'(core_reset), 32'd1);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_byte_count", 32'(byte_count), 32'd0);
      chk("rst_mem0", 32'(instruction_mem[0]), 32'h00);
      chk("rst_mem255", 32'(instruction_mem[255]), 32'h00);
      reset_n = 1'b1;
      edge_();
      edge_();

      // 8-byte image, continuous valid
      q = {};
      for (int i = 0; i < 8; i++) q.push_back(8'h20 + 8'(i));
      start();
      stream(q, 100, 1'b1);
      finish_load();
      chk("t2_mem0", 32'(instruction_mem[0]), 32'h20);
      chk("t2_mem7", 32'(instruction_mem[7]), 32'h27);
      chk("t2_mem8", 32'(instruction_mem[8]), 32'h00);
      chk("t2_byte_count", 32'(byte_count), 32'd8);
      chk("t2_load_done", 32'(load_done), 32'd1);
      chk("t2_release_latency", 32'((fall_t - last_t) / 10), 32'd250);

      // Same image, bursty valid
      start();
      stream(q, 50, 1'b1);
      finish_load();
      chk("t3_byte_count", 32'(byte_count), 32'd8);
      chk("t3_mem5", 32'(instruction_mem[5]), 32'h25);

      // Overflowing 260-byte image
      q = {};
      for (int i = 0; i < 260; i++) q.push_back(8'(i) ^ 8'hA5);
      start();
      stream(q, 100, 1'b1);
      finish_load();
      chk("t4_overflow", 32'(overflow_err), 32'd1);
      chk("t4_byte_count", 32'(byte_count), 32'd256);
      chk("t4_mem0", 32'(instruction_mem[0]), 32'hA5);
      chk("t4_mem255", 32'(instruction_mem[255]), 32'h5A);
      chk("t4_release_latency", 32'((fall_t - last_t) / 10), 32'd2);

      // Reload from RUN with a short image
      q = {8'hC0, 8'hC1, 8'hC2, 8'hC3};
      start();
      chk("t5_core_reset_rehold", 32'(core_reset), 32'd1);
      stream(q, 100, 1'b1);
      finish_load();
      chk("t5_mem0", 32'(instruction_mem[0]), 32'hC0);
      chk("t5_mem4", 32'(instruction_mem[4]), 32'h00);
      chk("t5_overflow", 32'(overflow_err), 32'd0);

      // Async reset in the middle of a load, then a fresh load
      q = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
      start();
      stream(q, 100, 1'b0);
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("t6_in_ready", 32'(in_ready), 32'd0);
      chk("t6_core_reset", 32'(core_reset), 32'd1);
      chk("t6_byte_count", 32'(byte_count), 32'd0);
      chk("t6_mem0", 32'(instruction_mem[0]), 32'h00);
      chk("t6_load_done", 32'(load_done), 32'd0);
      edge_();
      edge_();
      reset_n = 1'b1;
      edge_();
      q = {8'h31, 8'h32, 8'h33};
      start();
      stream(q, 100, 1'b1);
      finish_load();
      chk("t6_mem2", 32'(instruction_mem[2]), 32'h33);
      chk("t6_mem3", 32'(instruction_mem[3]), 32'h00);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
